// File: rtl/qeip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qeip_pkg
// Description : Shared definitions for the Grover QEIP APB register window:
//               register offsets inside the 1 KiB window, APB master state
//               encoding, and the function-table word count derivation used
//               by both the master and the accelerator slave.
// Revision    : 1.0 - initial release
// ============================================================================
package qeip_pkg;

    // Register offsets inside the accelerator window
    localparam logic [9:0] QEIP_OFF_TABLE = 10'h000;
    localparam logic [9:0] QEIP_OFF_RUN   = 10'h100;

    // APB master state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETUP  = ST_SETUP,
        S_ACCESS = ST_ACCESS,
        S_DONE   = ST_DONE
    } qeip_state_t;

    // Which part of a command the master is in
    typedef enum logic {
        PH_LOAD = 1'b0,
        PH_RUN  = 1'b1
    } qeip_phase_t;

    // One table bit per basis state, packed BW_DATA bits per word; a table
    // smaller than one word still occupies a full word.
    function automatic int qeip_num_table(input int num_qubit, input int bw_data);
        int exponent;
        exponent = num_qubit - $clog2(bw_data);
        return (exponent > 0) ? (1 << exponent) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qeip_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : qeip_wait_timer
// Description : Saturating wait-state counter with clear, enable and
//               threshold compare. timeout is high while the count is at or
//               above THRESHOLD; THRESHOLD = 0 disables the flag entirely.
// Ports       : clk     - clock
//               rstnn   - asynchronous active-low reset
//               clr     - synchronous clear (wins over en)
//               en      - count one wait cycle
//               timeout - registered threshold flag
// Revision    : 1.0 - initial release
// ============================================================================
module qeip_wait_timer #(
    parameter int THRESHOLD = 4096
) (
    input  logic clk,
    input  logic rstnn,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    generate
        if (THRESHOLD == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = clk ^ rstnn ^ clr ^ en;
            assign timeout       = 1'b0;
        end else begin : g_enabled
            localparam int             CW    = $clog2(THRESHOLD + 1);
            localparam logic [CW-1:0]  LIMIT = CW'(THRESHOLD);

            logic [CW-1:0] count;
            logic [CW-1:0] count_nxt;

            // Saturating at the threshold keeps the counter narrow and makes
            // "count >= THRESHOLD" a plain equality.
            always_comb begin
                count_nxt = count;
                if (clr) begin
                    count_nxt = '0;
                end else if (en && (count != LIMIT)) begin
                    count_nxt = count + CW'(1);
                end
            end

            // The flag is loaded from the same next value as the counter so
            // both registers always agree.
            always_ff @(posedge clk or negedge rstnn) begin
                if (!rstnn) begin
                    count   <= '0;
                    timeout <= 1'b0;
                end else begin
                    count   <= count_nxt;
                    timeout <= (count_nxt == LIMIT);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/qeip_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : qeip_apb_master
// Description : APB initiator for the Grover QEIP accelerator window. One
//               start command writes the oracle function table (unless
//               start_run_only), issues the blocking run read and returns
//               prdata[NUM_QUBIT:0] of that read with a sticky error flag.
// Ports       : clk, rstnn              - clock, async active-low reset
//               start, start_run_only   - command pulse and its mode bit
//               table_bits              - oracle table, word j at
//                                         [BW_DATA*(j+1)-1 -: BW_DATA]
//               busy                    - command in progress
//               result_valid            - one-cycle result strobe
//               result_data, result_err - run read value, OR of pslverr
//               timeout                 - current access waited too long
//               psel..pslverr           - APB master port
// Notes       : NUM_QUBIT must be 1..10 and BASE_ADDR 1 KiB aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module qeip_apb_master
    import qeip_pkg::*;
#(
    parameter int                 BW_DATA        = 32,
    parameter int                 BW_ADDR        = 32,
    parameter int                 NUM_QUBIT      = 5,
    parameter logic [BW_ADDR-1:0] BASE_ADDR      = '0,
    parameter int                 SLVERR_DELAY   = 1,
    parameter int                 TIMEOUT_CYCLES = 4096,
    localparam int                NUM_TABLE      = qeip_num_table(NUM_QUBIT, BW_DATA)
) (
    input  logic                         clk,
    input  logic                         rstnn,
    input  logic                         start,
    input  logic                         start_run_only,
    input  logic [NUM_TABLE*BW_DATA-1:0] table_bits,
    output logic                         busy,
    output logic                         result_valid,
    output logic [NUM_QUBIT:0]           result_data,
    output logic                         result_err,
    output logic                         timeout,
    output logic                         psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [BW_ADDR-1:0]           paddr,
    output logic [BW_DATA-1:0]           pwdata,
    input  logic [BW_DATA-1:0]           prdata,
    input  logic                         pready,
    input  logic                         pslverr
);

    localparam int                 IW       = (NUM_TABLE > 1) ? $clog2(NUM_TABLE) : 1;
    localparam logic [BW_ADDR-1:0] RUN_ADDR = BASE_ADDR + BW_ADDR'(QEIP_OFF_RUN);

    qeip_state_t                  state;
    qeip_phase_t                  phase;
    logic [IW-1:0]                idx;
    logic [IW-1:0]                idx_nxt;
    logic [NUM_TABLE*BW_DATA-1:0] table_q;
    logic                         err;
    logic                         err_sample;
    logic [NUM_QUBIT:0]           run_data;
    logic                         wait_clr;
    logic                         wait_en;
    logic                         unused_prdata;

    // Only the measured state index of the run read is returned
    assign unused_prdata = ^prdata[BW_DATA-1:NUM_QUBIT+1];

    function automatic logic [BW_ADDR-1:0] table_addr(input logic [IW-1:0] i);
        logic [9:0] off;
        off = QEIP_OFF_TABLE + 10'({i, 2'b00});
        return BASE_ADDR + BW_ADDR'(off);
    endfunction

    function automatic logic [BW_DATA-1:0] table_word(
        input logic [NUM_TABLE*BW_DATA-1:0] t,
        input logic [IW-1:0]                i
    );
        return t[BW_DATA*int'(i) +: BW_DATA];
    endfunction

    assign idx_nxt = idx + IW'(1);

    // ------------------------------------------------------------------
    // pslverr sampling point
    // ------------------------------------------------------------------
    generate
        if (SLVERR_DELAY == 0) begin : g_slverr_now
            // penable is only ever high in ACCESS
            assign err_sample = pslverr && penable && pready;
        end else begin : g_slverr_late
            logic completed;
            always_ff @(posedge clk or negedge rstnn) begin
                if (!rstnn) begin
                    completed <= 1'b0;
                end else begin
                    completed <= penable && pready;
                end
            end
            // The cycle after a completion is always the next SETUP or DONE
            assign err_sample = pslverr && completed;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Wait-state timer: restarted outside ACCESS and on completion so the
    // flag only describes the transfer currently stalled on pready.
    // ------------------------------------------------------------------
    assign wait_clr = (state != S_ACCESS) || pready;
    assign wait_en  = (state == S_ACCESS) && !pready;

    qeip_wait_timer #(
        .THRESHOLD (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rstnn   (rstnn),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (timeout)
    );

    // ------------------------------------------------------------------
    // Command FSM. The state register names the bus phase currently being
    // driven, so every APB output is loaded on the edge that enters it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state        <= S_IDLE;
            phase        <= PH_LOAD;
            idx          <= '0;
            table_q      <= '0;
            err          <= 1'b0;
            run_data     <= '0;
            psel         <= 1'b0;
            penable      <= 1'b0;
            pwrite       <= 1'b0;
            paddr        <= BASE_ADDR;
            pwdata       <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_err   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (err_sample) begin
                err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        table_q <= table_bits;
                        idx     <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= S_SETUP;
                        if (start_run_only) begin
                            phase  <= PH_RUN;
                            paddr  <= RUN_ADDR;
                            pwrite <= 1'b0;
                            pwdata <= '0;
                        end else begin
                            // Word 0 comes straight from the input; the
                            // captured copy is only ready next cycle.
                            phase  <= PH_LOAD;
                            paddr  <= table_addr('0);
                            pwrite <= 1'b1;
                            pwdata <= table_bits[BW_DATA-1:0];
                        end
                    end
                end

                S_SETUP: begin
                    penable <= 1'b1;
                    state   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (pready) begin
                        penable <= 1'b0;
                        if (phase == PH_LOAD) begin
                            state <= S_SETUP;
                            if (int'(idx) < NUM_TABLE - 1) begin
                                idx    <= idx_nxt;
                                paddr  <= table_addr(idx_nxt);
                                pwdata <= table_word(table_q, idx_nxt);
                            end else begin
                                phase  <= PH_RUN;
                                paddr  <= RUN_ADDR;
                                pwrite <= 1'b0;
                                pwdata <= '0;
                            end
                        end else begin
                            run_data <= prdata[NUM_QUBIT:0];
                            psel     <= 1'b0;
                            state    <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // A delayed pslverr for the run read lands in this cycle
                    state        <= S_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b1;
                    result_data  <= run_data;
                    result_err   <= err || err_sample;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
